// File: rtl/enc_pri_scan.sv
// rtl/enc_pri_scan.sv - priority encoder with single/scan modes and valid/ready handshake
module enc_pri_scan #(
   parameter int WIDTH       = 8,
   parameter bit MSB_FIRST   = 1'b1,
   localparam int IDX_W      = $clog2(WIDTH),
   localparam int CNT_W      = $clog2(WIDTH + 1)
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [WIDTH-1:0]  in_data_i,
   input  logic              in_mode_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [IDX_W-1:0]  out_idx_o,
   output logic              out_found_o,
   output logic              out_onehot_o,
   output logic              out_last_o,
   output logic [CNT_W-1:0]  out_cnt_o
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SCAN = 1'b1;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [0:0]        state_q;
   logic [WIDTH-1:0]  resid_q;

   logic              accept;
   logic              handoff;
   logic [IDX_W-1:0]  in_idx;
   logic [CNT_W-1:0]  in_cnt;
   logic [WIDTH-1:0]  in_rem;
   logic              in_multi;
   logic [IDX_W-1:0]  scan_idx;
   logic [WIDTH-1:0]  scan_rem;

   // Index of the highest-priority set bit; 0 for an all-zero vector.
   // The later match in loop order wins, so the loop direction sets the priority.
   function automatic logic [IDX_W-1:0] pri_idx(input logic [WIDTH-1:0] v);
      logic [IDX_W-1:0] r;
      r = '0;
      if (MSB_FIRST) begin
         for (int i = 0; i < WIDTH; i++)
            if (v[i]) r = IDX_W'(i);
      end else begin
         for (int i = WIDTH - 1; i >= 0; i--)
            if (v[i]) r = IDX_W'(i);
      end
      return r;
   endfunction

   // Number of set bits in the vector.
   function automatic logic [CNT_W-1:0] pop_cnt(input logic [WIDTH-1:0] v);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < WIDTH; i++)
         c = c + CNT_W'(v[i]);
      return c;
   endfunction

   // A new word may enter only from IDLE, and only when the output slot is free or draining.
   assign in_ready_o = rst_n_i && (state_q == ST_IDLE) && (!out_valid_o || out_ready_i);
   assign accept     = in_valid_i && in_ready_o;
   assign handoff    = out_valid_o && out_ready_i;

   // Encode the incoming word and the residual mask in parallel.
   always_comb begin
      in_idx   = pri_idx(in_data_i);
      in_cnt   = pop_cnt(in_data_i);
      in_rem   = in_data_i & ~(ONE << in_idx);
      in_multi = in_mode_i && (in_cnt > CNT_W'(1));
      scan_idx = pri_idx(resid_q);
      scan_rem = resid_q & ~(ONE << scan_idx);
   end

   // Output registers, residual mask and IDLE/SCAN sequencing.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= ST_IDLE;
         resid_q      <= '0;
         out_valid_o  <= 1'b0;
         out_idx_o    <= '0;
         out_found_o  <= 1'b0;
         out_onehot_o <= 1'b0;
         out_last_o   <= 1'b0;
         out_cnt_o    <= '0;
      end else if (accept) begin
         out_valid_o  <= 1'b1;
         out_idx_o    <= in_idx;
         out_found_o  <= |in_data_i;
         out_onehot_o <= (in_cnt == CNT_W'(1));
         out_cnt_o    <= in_cnt;
         if (in_multi) begin
            out_last_o <= 1'b0;
            resid_q    <= in_rem;
            state_q    <= ST_SCAN;
         end else begin
            out_last_o <= 1'b1;
            resid_q    <= '0;
         end
      end else if (state_q == ST_SCAN) begin
         // The residual always holds at least one bit here; found/onehot/cnt stay from the word.
         if (handoff) begin
            out_idx_o  <= scan_idx;
            resid_q    <= scan_rem;
            out_last_o <= (scan_rem == '0);
            if (scan_rem == '0)
               state_q <= ST_IDLE;
         end
      end else if (handoff) begin
         out_valid_o <= 1'b0;
      end
   end

endmodule
